// File: rtl/led_bar_timer.sv
// Countdown timer driving an N-LED bar display with bar/dot/blink decode,
// pause via En, optional auto-reload and a synchronous reconfiguration load.
module led_bar_timer #(
  parameter int N_LED     = 10,
  parameter int TICK_W    = 26,
  parameter int DEF_TICKS = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              En,
  input  logic              Reconfigure,
  input  logic [TICK_W-1:0] cfg_ticks,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_autoreload,
  output logic [N_LED-1:0]  LED,
  output logic              LED_timeout,
  output logic              busy
);

  localparam int RW = $clog2(N_LED + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] M_BAR   = 2'd0;
  localparam logic [1:0] M_DOT   = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;

  localparam logic [RW-1:0]     REM_FULL   = RW'(N_LED);
  localparam logic [TICK_W-1:0] PERIOD_RST = TICK_W'(DEF_TICKS);

  logic [1:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [RW-1:0]     remain_q, remain_d;
  logic [TICK_W-1:0] period_q, period_d;
  logic [1:0]        mode_q, mode_d;
  logic              autoreload_q, autoreload_d;

  logic              advance;
  logic              step_end;

  assign step_end = (tick_cnt_q == period_q - TICK_W'(1));

  // PAUSE->RUN counts on the resume edge so a pause costs exactly its length.
  assign advance = En && ((state_q == S_RUN) || (state_q == S_PAUSE));

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    remain_d     = remain_q;
    period_d     = period_q;
    mode_d       = mode_q;
    autoreload_d = autoreload_q;

    if (Reconfigure) begin
      period_d     = (cfg_ticks == '0) ? TICK_W'(1) : cfg_ticks;
      mode_d       = (cfg_mode == 2'd3) ? M_BAR : cfg_mode;
      autoreload_d = cfg_autoreload;
      state_d      = S_IDLE;
      remain_d     = REM_FULL;
      tick_cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (En) begin
            state_d    = S_RUN;
            remain_d   = REM_FULL;
            tick_cnt_d = '0;
          end
        end
        S_RUN: begin
          if (!En) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (En) state_d = S_RUN;
        end
        default: begin
          if (autoreload_q) begin
            state_d    = S_RUN;
            remain_d   = REM_FULL;
            tick_cnt_d = '0;
          end else if (!En) begin
            state_d    = S_IDLE;
            remain_d   = REM_FULL;
            tick_cnt_d = '0;
          end
        end
      endcase

      if (advance) begin
        if (step_end) begin
          tick_cnt_d = '0;
          remain_d   = remain_q - RW'(1);
          if (remain_q == RW'(1)) state_d = S_DONE;
        end else begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      remain_q     <= REM_FULL;
      period_q     <= PERIOD_RST;
      mode_q       <= M_BAR;
      autoreload_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      remain_q     <= remain_d;
      period_q     <= period_d;
      mode_q       <= mode_d;
      autoreload_q <= autoreload_d;
    end
  end

  logic [N_LED-1:0] bar_pat;
  logic [N_LED-1:0] top_pat;
  logic [N_LED-1:0] led_pat;
  logic             phase;

  // Decode reads registers only, so LED has no combinational path from inputs.
  always_comb begin
    bar_pat = '0;
    top_pat = '0;
    for (int i = 0; i < N_LED; i++) begin
      bar_pat[i] = (RW'(i) < remain_q);
      top_pat[i] = (RW'(i + 1) == remain_q);
    end
    phase = (tick_cnt_q >= (period_q >> 1));
    case (mode_q)
      M_DOT:   led_pat = top_pat;
      M_BLINK: led_pat = bar_pat & ~(top_pat & {N_LED{~phase}});
      default: led_pat = bar_pat;
    endcase
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign LED_timeout = (state_q == S_DONE);
  assign LED         = busy ? led_pat : '0;

endmodule

// File: tb/tb_led_bar_timer.sv
// Directed bench for led_bar_timer with N_LED=4, DEF_TICKS=3.
module tb_led_bar_timer;

  localparam int NL = 4;
  localparam int TW = 8;

  logic          clk;
  logic          rst;
  logic          En;
  logic          Reconfigure;
  logic [TW-1:0] cfg_ticks;
  logic [1:0]    cfg_mode;
  logic          cfg_autoreload;
  logic [NL-1:0] LED;
  logic          LED_timeout;
  logic          busy;

  int total = 0;
  int bad   = 0;

  led_bar_timer #(.N_LED(NL), .TICK_W(TW), .DEF_TICKS(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .En            (En),
    .Reconfigure   (Reconfigure),
    .cfg_ticks     (cfg_ticks),
    .cfg_mode      (cfg_mode),
    .cfg_autoreload(cfg_autoreload),
    .LED           (LED),
    .LED_timeout   (LED_timeout),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bar_of(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int dot_of(input int r);
    return (r == 0) ? 0 : (1 << (r - 1));
  endfunction

  task automatic cfg(input int ticks, input int md, input logic ar);
    Reconfigure    = 1'b1;
    En             = 1'b0;
    cfg_ticks      = TW'(ticks);
    cfg_mode       = 2'(md);
    cfg_autoreload = ar;
    @(negedge clk);
    Reconfigure = 1'b0;
    chk("cfg_busy", 32'(busy), 0);
  endtask

  // Raises En from IDLE and checks nk consecutive cycles against the model.
  task automatic run_seq(input string tag, input int per, input int md, input bit ar,
                         input int nk);
    int j, rem, t, pat;
    En = 1'b1;
    for (int k = 0; k < nk; k++) begin
      @(negedge clk);
      j = ar ? (k % (NL * per + 1)) : k;
      if (j >= NL * per) begin
        chk({tag, "_led"}, 32'(LED), 0);
        chk({tag, "_to"}, 32'(LED_timeout), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
      end else begin
        rem = NL - j / per;
        t   = j % per;
        case (md)
          1:       pat = dot_of(rem);
          2:       pat = (t >= per / 2) ? bar_of(rem) : bar_of(rem - 1);
          default: pat = bar_of(rem);
        endcase
        chk({tag, "_led"}, 32'(LED), 32'(pat));
        chk({tag, "_to"}, 32'(LED_timeout), 0);
        chk({tag, "_busy"}, 32'(busy), 1);
      end
    end
  endtask

  initial begin
    int c;
    rst = 1'b0; En = 1'b0; Reconfigure = 1'b0;
    cfg_ticks = '0; cfg_mode = '0; cfg_autoreload = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(LED), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_led", 32'(LED), 0);
    chk("idle_to", 32'(LED_timeout), 0);
    chk("idle_busy", 32'(busy), 0);

    // Bar countdown at default period, timeout held until En drops.
    run_seq("bar", 3, 0, 0, 13);
    repeat (2) begin
      @(negedge clk);
      chk("bar_hold_to", 32'(LED_timeout), 1);
    end
    En = 1'b0;
    @(negedge clk);
    chk("bar_clr_to", 32'(LED_timeout), 0);
    chk("bar_clr_busy", 32'(busy), 0);

    // Pause: En low on edges 5..9, expiry moves from edge 12 to edge 17.
    En = 1'b1;
    c  = 0;
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (k >= 1 && !(k >= 5 && k <= 9)) c++;
      if (c >= NL * 3) begin
        chk("pause_to", 32'(LED_timeout), 1);
        chk("pause_led", 32'(LED), 0);
      end else begin
        chk("pause_to", 32'(LED_timeout), 0);
        chk("pause_led", 32'(LED), 32'(bar_of(NL - c / 3)));
        chk("pause_busy", 32'(busy), 1);
      end
      En = !((k + 1) >= 5 && (k + 1) <= 9);
    end
    chk("pause_end_k", 32'(c), 12);
    En = 1'b0;
    @(negedge clk);

    cfg(2, 1, 1'b0);
    run_seq("dot2", 2, 1, 0, 9);
    cfg(0, 1, 1'b0);
    run_seq("dot1", 1, 1, 0, 5);
    cfg(3, 0, 1'b1);
    run_seq("auto", 3, 0, 1, 27);
    cfg(3, 3, 1'b0);
    run_seq("mode3", 3, 0, 0, 4);

    // Reconfigure mid-run aborts to IDLE even with En held high.
    cfg(3, 0, 1'b0);
    En = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 1);
    Reconfigure = 1'b1;
    @(negedge clk);
    Reconfigure = 1'b0;
    chk("abort_led", 32'(LED), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_to", 32'(LED_timeout), 0);

    // Asynchronous reset mid-run restores default period and bar mode.
    cfg(5, 1, 1'b1);
    En = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_pre_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_led", 32'(LED), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_to", 32'(LED_timeout), 0);
    En = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_seq("rst_def", 3, 0, 0, 5);

    cfg(4, 2, 1'b0);
    run_seq("blink", 4, 2, 0, 9);
    En = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
